// File: rtl/locus_pkg.sv
// Shared types and constants for the colour-locus tracking filter.
package locus_pkg;

    localparam int COORD_W = 10;
    localparam int VEL_W   = 11;
    localparam int NUM_CH  = 3;

    localparam logic [1:0] CH_RED   = 2'd0;
    localparam logic [1:0] CH_GREEN = 2'd1;
    localparam logic [1:0] CH_BLUE  = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        CAPTURE,
        FILT0,
        FILT1,
        FILT2,
        PRESENT
    } state_t;

endpackage

// File: rtl/locus_axis_filter.sv
// Single-axis gate test, exponential smoothing step and velocity for one channel.
// Velocity output is only produced when LOCUS_VELOCITY_EN is defined.
module locus_axis_filter
    import locus_pkg::*;
#(
    parameter int ALPHA_SHIFT = 2,
    parameter int JUMP_MAX    = 64
) (
    input  logic [COORD_W-1:0]       meas,
    input  logic [COORD_W-1:0]       filt,
    input  logic                     track_ok,
    output logic                     near,
    output logic [COORD_W-1:0]       filt_next,
    output logic signed [VEL_W-1:0]  vel
);

    logic signed [VEL_W-1:0] diff;
    logic signed [VEL_W-1:0] mag;
    logic signed [VEL_W-1:0] step;
    logic signed [VEL_W-1:0] sum;

    // The 11-bit signed difference covers the full +/-1023 range of two 10-bit coordinates.
    always_comb begin
        diff      = $signed({1'b0, meas}) - $signed({1'b0, filt});
        mag       = diff[VEL_W-1] ? -diff : diff;
        near      = (int'(mag) <= JUMP_MAX);
        step      = diff >>> ALPHA_SHIFT;
        sum       = $signed({1'b0, filt}) + step;
        filt_next = track_ok ? COORD_W'(sum) : meas;
`ifdef LOCUS_VELOCITY_EN
        vel       = track_ok ? step : '0;
`else
        vel       = '0;
`endif
    end

endmodule

// File: rtl/locus_filter.sv
// Frame-sequenced tracker: starts the locus search, captures its results and smooths three channels.
// Define LOCUS_VELOCITY_EN to enable the per-channel velocity outputs (otherwise they are tied to 0).
module locus_filter
    import locus_pkg::*;
#(
    parameter int ALPHA_SHIFT = 2,
    parameter int JUMP_MAX    = 64,
    parameter int MISS_MAX    = 4,
    parameter int TIMEOUT     = 1 << 20
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     frame_ready,
    output logic                     hunt_start,
    input  logic                     hunt_done,
    input  logic [COORD_W-1:0]       red_x,
    input  logic [COORD_W-1:0]       red_y,
    input  logic [COORD_W-1:0]       green_x,
    input  logic [COORD_W-1:0]       green_y,
    input  logic [COORD_W-1:0]       blue_x,
    input  logic [COORD_W-1:0]       blue_y,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [COORD_W-1:0]       filt_x [NUM_CH],
    output logic [COORD_W-1:0]       filt_y [NUM_CH],
    output logic signed [VEL_W-1:0]  vel_x [NUM_CH],
    output logic signed [VEL_W-1:0]  vel_y [NUM_CH],
    output logic [NUM_CH-1:0]        track_ok,
    output logic                     overrun
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int MW = $clog2(MISS_MAX + 1);

    state_t state, next_state;

    logic                armed;
    logic [TW-1:0]       wait_cnt;
    logic                timeout_hit;
    logic [COORD_W-1:0]  raw_x  [NUM_CH];
    logic [COORD_W-1:0]  raw_y  [NUM_CH];
    logic [COORD_W-1:0]  meas_x [NUM_CH];
    logic [COORD_W-1:0]  meas_y [NUM_CH];
    logic [MW-1:0]       miss_cnt [NUM_CH];

    logic                filt_en;
    logic [1:0]          ch;
    logic [COORD_W-1:0]  cur_mx, cur_my, cur_fx, cur_fy;
    logic [COORD_W-1:0]  upd_x, upd_y;
    logic                cur_trk, near_x, near_y, hit;

    assign raw_x       = '{red_x, green_x, blue_x};
    assign raw_y       = '{red_y, green_y, blue_y};
    assign timeout_hit = (wait_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // The FILT states double as the channel selector for the shared axis filters.
    always_comb begin
        next_state = state;
        hunt_start = 1'b0;
        out_valid  = 1'b0;
        filt_en    = 1'b0;
        ch         = CH_RED;
        case (state)
            IDLE:    if (frame_ready && armed) next_state = START;
            START: begin
                hunt_start = 1'b1;
                next_state = WAIT;
            end
            WAIT: begin
                if (hunt_done)        next_state = CAPTURE;
                else if (timeout_hit) next_state = FILT0;
            end
            CAPTURE: next_state = FILT0;
            FILT0: begin
                filt_en    = 1'b1;
                ch         = CH_RED;
                next_state = FILT1;
            end
            FILT1: begin
                filt_en    = 1'b1;
                ch         = CH_GREEN;
                next_state = FILT2;
            end
            FILT2: begin
                filt_en    = 1'b1;
                ch         = CH_BLUE;
                next_state = PRESENT;
            end
            PRESENT: begin
                out_valid = 1'b1;
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // A timed-out search is recorded as (0,0) on every channel so the filter stage sees three misses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed    <= 1'b0;
            wait_cnt <= '0;
            overrun  <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                meas_x[c] <= '0;
                meas_y[c] <= '0;
            end
        end else begin
            armed    <= 1'b1;
            wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
            if (frame_ready && (state != IDLE)) overrun <= 1'b1;
            if (state == WAIT) begin
                if (hunt_done) begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        meas_x[c] <= raw_x[c];
                        meas_y[c] <= raw_y[c];
                    end
                end else if (timeout_hit) begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        meas_x[c] <= '0;
                        meas_y[c] <= '0;
                    end
                end
            end
        end
    end

    always_comb begin
        cur_mx  = meas_x[ch];
        cur_my  = meas_y[ch];
        cur_fx  = filt_x[ch];
        cur_fy  = filt_y[ch];
        cur_trk = track_ok[ch];
        hit     = ((cur_mx != '0) || (cur_my != '0)) && (!cur_trk || (near_x && near_y));
    end

`ifdef LOCUS_VELOCITY_EN
    logic signed [VEL_W-1:0] step_x, step_y;
`endif

    locus_axis_filter #(
        .ALPHA_SHIFT (ALPHA_SHIFT),
        .JUMP_MAX    (JUMP_MAX)
    ) u_axis_x (
        .meas        (cur_mx),
        .filt        (cur_fx),
        .track_ok    (cur_trk),
        .near        (near_x),
        .filt_next   (upd_x),
`ifdef LOCUS_VELOCITY_EN
        .vel         (step_x)
`else
        .vel         ()
`endif
    );

    locus_axis_filter #(
        .ALPHA_SHIFT (ALPHA_SHIFT),
        .JUMP_MAX    (JUMP_MAX)
    ) u_axis_y (
        .meas        (cur_my),
        .filt        (cur_fy),
        .track_ok    (cur_trk),
        .near        (near_y),
        .filt_next   (upd_y),
`ifdef LOCUS_VELOCITY_EN
        .vel         (step_y)
`else
        .vel         ()
`endif
    );

    // Lock is dropped on the miss that brings the counter up to MISS_MAX; the counter then saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            track_ok <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                filt_x[c]   <= '0;
                filt_y[c]   <= '0;
                miss_cnt[c] <= '0;
            end
        end else if (filt_en) begin
            if (hit) begin
                filt_x[ch]   <= upd_x;
                filt_y[ch]   <= upd_y;
                miss_cnt[ch] <= '0;
                track_ok[ch] <= 1'b1;
            end else if (miss_cnt[ch] != MW'(MISS_MAX)) begin
                miss_cnt[ch] <= miss_cnt[ch] + 1'b1;
                if (miss_cnt[ch] == MW'(MISS_MAX - 1)) track_ok[ch] <= 1'b0;
            end
        end
    end

`ifdef LOCUS_VELOCITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                vel_x[c] <= '0;
                vel_y[c] <= '0;
            end
        end else if (filt_en) begin
            vel_x[ch] <= hit ? step_x : '0;
            vel_y[ch] <= hit ? step_y : '0;
        end
    end
`else
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            vel_x[c] = '0;
            vel_y[c] = '0;
        end
    end
`endif

endmodule

// File: tb/tb_locus_filter.sv
// Self-checking bench for locus_filter: a frame-level reference model plus pinned literal expectations.
module tb_locus_filter;

    localparam int ALPHA_SHIFT = 2;
    localparam int JUMP_MAX    = 64;
    localparam int MISS_MAX    = 4;
    localparam int TIMEOUT     = 40;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              frame_ready = 1'b0;
    logic              hunt_start;
    logic              hunt_done = 1'b0;
    logic [9:0]        red_x = '0, red_y = '0, green_x = '0, green_y = '0, blue_x = '0, blue_y = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [9:0]        filt_x [3];
    logic [9:0]        filt_y [3];
    logic signed [10:0] vel_x [3];
    logic signed [10:0] vel_y [3];
    logic [2:0]        track_ok;
    logic              overrun;

    int checks = 0;
    int errors = 0;

    int mfx [3], mfy [3], mvx [3], mvy [3], mmiss [3];
    bit mtrk [3];
    bit exp_overrun;
    int hs_count = 0;
    int sx [3], sy [3];

    locus_filter #(
        .ALPHA_SHIFT (ALPHA_SHIFT),
        .JUMP_MAX    (JUMP_MAX),
        .MISS_MAX    (MISS_MAX),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_ready (frame_ready),
        .hunt_start  (hunt_start),
        .hunt_done   (hunt_done),
        .red_x       (red_x),
        .red_y       (red_y),
        .green_x     (green_x),
        .green_y     (green_y),
        .blue_x      (blue_x),
        .blue_y      (blue_y),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .filt_x      (filt_x),
        .filt_y      (filt_y),
        .vel_x       (vel_x),
        .vel_y       (vel_y),
        .track_ok    (track_ok),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int absval(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic modelReset();
        for (int c = 0; c < 3; c++) begin
            mfx[c] = 0; mfy[c] = 0; mvx[c] = 0; mvy[c] = 0; mmiss[c] = 0; mtrk[c] = 0;
        end
        exp_overrun = 0;
    endtask

    // One whole frame of the tracking rules; a timed-out search counts as "not found" on every channel.
    task automatic modelFrame(input bit timed_out);
        int px, py, dx, dy, nx, ny;
        bit hit;
        for (int c = 0; c < 3; c++) begin
            px  = timed_out ? 0 : sx[c];
            py  = timed_out ? 0 : sy[c];
            dx  = px - mfx[c];
            dy  = py - mfy[c];
            hit = (px != 0 || py != 0) &&
                  (!mtrk[c] || (absval(dx) <= JUMP_MAX && absval(dy) <= JUMP_MAX));
            if (hit) begin
                if (!mtrk[c]) begin
                    mfx[c] = px; mfy[c] = py; mvx[c] = 0; mvy[c] = 0; mtrk[c] = 1;
                end else begin
                    nx = mfx[c] + (dx >>> ALPHA_SHIFT);
                    ny = mfy[c] + (dy >>> ALPHA_SHIFT);
                    mvx[c] = nx - mfx[c];
                    mvy[c] = ny - mfy[c];
                    mfx[c] = nx;
                    mfy[c] = ny;
                end
                mmiss[c] = 0;
            end else begin
                mvx[c] = 0;
                mvy[c] = 0;
                if (mmiss[c] < MISS_MAX) mmiss[c]++;
                if (mmiss[c] == MISS_MAX) mtrk[c] = 0;
            end
`ifndef LOCUS_VELOCITY_EN
            mvx[c] = 0;
            mvy[c] = 0;
`endif
        end
    endtask

    always @(negedge clk) begin
        if (hunt_start) hs_count++;
    end

    // Whenever a result is on offer it must match the model, which also proves it is held stable.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            for (int c = 0; c < 3; c++) begin
                checkOutput($sformatf("filt_x[%0d]", c), int'(filt_x[c]), mfx[c]);
                checkOutput($sformatf("filt_y[%0d]", c), int'(filt_y[c]), mfy[c]);
                checkOutput($sformatf("vel_x[%0d]", c), int'(vel_x[c]), mvx[c]);
                checkOutput($sformatf("vel_y[%0d]", c), int'(vel_y[c]), mvy[c]);
            end
            checkOutput("track_ok", int'(track_ok), int'({mtrk[2], mtrk[1], mtrk[0]}));
            checkOutput("overrun", int'(overrun), int'(exp_overrun));
        end
    end

    task automatic driveMeas();
        red_x   = 10'(sx[0]); red_y   = 10'(sy[0]);
        green_x = 10'(sx[1]); green_y = 10'(sy[1]);
        blue_x  = 10'(sx[2]); blue_y  = 10'(sy[2]);
    endtask

    task automatic scrambleMeas();
        red_x   = 10'($urandom); red_y   = 10'($urandom);
        green_x = 10'($urandom); green_y = 10'($urandom);
        blue_x  = 10'($urandom); blue_y  = 10'($urandom);
    endtask

    task automatic applyStimulus(input bit send_done, input int hold, input bit poke_frame);
        int  k;
        int  hs0;
        bit  seen;
        @(posedge clk); #1 frame_ready = 1'b1;
        @(posedge clk); #1 frame_ready = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = hunt_start;
        end
        checkOutput("hunt_start_seen", int'(seen), 1);
        if (!seen) return;
        if (send_done) begin
            @(posedge clk);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            driveMeas();
            hunt_done = 1'b1;
            modelFrame(1'b0);
            @(posedge clk); #1;
            hunt_done = 1'b0;
            scrambleMeas();
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!out_valid && k < 20);
            checkOutput("latency", k, 5);
        end else begin
            modelFrame(1'b1);
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!out_valid && k < TIMEOUT + 20);
            checkOutput("timeout_window", int'(k >= TIMEOUT && k <= TIMEOUT + 6), 1);
        end
        if (!out_valid) return;
        hs0 = hs_count;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (poke_frame && i == 4) frame_ready = 1'b1;
            if (poke_frame && i == 5) begin
                frame_ready = 1'b0;
                exp_overrun = 1'b1;
            end
        end
        if (poke_frame) begin
            checkOutput("overrun_set", int'(overrun), 1);
            checkOutput("extra_hunt_start", hs_count - hs0, 0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        checkOutput("released", int'(out_valid), 0);
    endtask

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int hits;
        modelReset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_hunt_start", int'(hunt_start), 0);
        checkOutput("reset_track_ok", int'(track_ok), 0);
        checkOutput("reset_overrun", int'(overrun), 0);
        checkOutput("reset_filt_x0", int'(filt_x[0]), 0);
        checkOutput("reset_vel_x0", int'(vel_x[0]), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);

        sx = '{80, 300, 0}; sy = '{80, 500, 0};
        applyStimulus(1'b1, 2, 1'b0);
        checkOutput("lit_f1_filt_x0", int'(filt_x[0]), 80);
        checkOutput("lit_f1_filt_y0", int'(filt_y[0]), 80);
        checkOutput("lit_f1_vel_x0", int'(vel_x[0]), 0);
        checkOutput("lit_f1_track0", int'(track_ok[0]), 1);
        checkOutput("lit_f1_track2", int'(track_ok[2]), 0);

        sx = '{96, 310, 0}; sy = '{80, 490, 0};
        applyStimulus(1'b1, 0, 1'b0);
        checkOutput("lit_f2_filt_x0", int'(filt_x[0]), 84);
        checkOutput("lit_f2_filt_y0", int'(filt_y[0]), 80);
`ifdef LOCUS_VELOCITY_EN
        checkOutput("lit_f2_vel_x0", int'(vel_x[0]), 4);
`else
        checkOutput("lit_f2_vel_x0", int'(vel_x[0]), 0);
`endif
        checkOutput("lit_f2_vel_y0", int'(vel_y[0]), 0);
        checkOutput("lit_f2_filt_y1", int'(filt_y[1]), 497);

        sx = '{200, 302, 0}; sy = '{80, 497, 0};
        for (int f = 1; f <= 4; f++) begin
            applyStimulus(1'b1, 1, 1'b0);
            checkOutput("lit_jump_filt_x0", int'(filt_x[0]), 84);
            checkOutput("lit_jump_track0", int'(track_ok[0]), (f < 4) ? 1 : 0);
        end
        applyStimulus(1'b1, 1, 1'b0);
        checkOutput("lit_reload_filt_x0", int'(filt_x[0]), 200);
        checkOutput("lit_reload_track0", int'(track_ok[0]), 1);

        applyStimulus(1'b0, 1, 1'b0);
        checkOutput("lit_timeout_filt_x0", int'(filt_x[0]), 200);
        checkOutput("lit_timeout_vel_x0", int'(vel_x[0]), 0);

        sx = '{210, 302, 0}; sy = '{84, 497, 0};
        applyStimulus(1'b1, 10, 1'b1);

        for (int f = 0; f < 30; f++) begin
            for (int c = 0; c < 3; c++) begin
                int r, off;
                r = int'($urandom_range(0, 4));
                if (r == 0) begin
                    sx[c] = 0; sy[c] = 0;
                end else if (r <= 2 && mtrk[c]) begin
                    off = int'($urandom_range(0, 160)) - 80;
                    sx[c] = mfx[c] + off;
                    off = int'($urandom_range(0, 160)) - 80;
                    sy[c] = mfy[c] + off;
                    if (sx[c] < 0) sx[c] = 0;
                    if (sx[c] > 1023) sx[c] = 1023;
                    if (sy[c] < 0) sy[c] = 0;
                    if (sy[c] > 1023) sy[c] = 1023;
                end else begin
                    sx[c] = int'($urandom_range(1, 1023));
                    sy[c] = int'($urandom_range(0, 1023));
                end
            end
            applyStimulus(1'b1, int'($urandom_range(0, 3)), 1'b0);
        end

        for (int c = 0; c < 3; c++) begin
            sx[c] = mtrk[c] ? mfx[c] : 500;
            sy[c] = mtrk[c] ? mfy[c] : 500;
            if (sx[c] == 0 && sy[c] == 0) sx[c] = 500;
        end
        applyStimulus(1'b1, 0, 1'b0);
        checkOutput("pre_reset_track_ok", int'(track_ok), 7);

        @(posedge clk); #1 frame_ready = 1'b1;
        @(posedge clk); #1 frame_ready = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_hunt_start", int'(hunt_start), 0);
        checkOutput("async_out_valid", int'(out_valid), 0);
        checkOutput("async_track_ok", int'(track_ok), 0);
        checkOutput("async_filt_x1", int'(filt_x[1]), 0);
        checkOutput("async_overrun", int'(overrun), 0);
        modelReset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        sx = '{400, 401, 402}; sy = '{100, 101, 102};
        driveMeas();
        hunt_done = 1'b1;
        @(posedge clk); #1 hunt_done = 1'b0;
        hits = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid || hunt_start) hits++;
        end
        checkOutput("stray_hunt_done_ignored", hits, 0);

        applyStimulus(1'b1, 2, 1'b0);
        checkOutput("lit_final_filt_x2", int'(filt_x[2]), 402);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/locus_filter.md
LOCUS_FILTER -- requirements
Module: locus_filter

Interface
REQ-001 Parameter ALPHA_SHIFT, default 2: smoothing shift; new = old + ((meas - old) >>> ALPHA_SHIFT).
REQ-002 Parameter JUMP_MAX, default 64: largest per-axis |meas - filt| accepted as the same object.
REQ-003 Parameter MISS_MAX, default 4: consecutive misses before a channel is declared lost.
REQ-004 Parameter TIMEOUT, default 2^20: cycles to wait for hunt_done before the frame is abandoned.
REQ-005 clk  in  1  system clock; every register is on its rising edge.
REQ-006 rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-007 frame_ready  in  1  one-cycle pulse when a new camera frame is stored.
REQ-008 hunt_start  out  1  one-cycle start pulse to the colour-locus search stage.
REQ-009 hunt_done  in  1  one-cycle pulse: search results are valid.
REQ-010 red_x, red_y, green_x, green_y, blue_x, blue_y  in  10 each  raw locus from the search stage; a pair equal to (0,0) means "not found".
REQ-011 out_valid  out  1  filtered result available; held until accepted.
REQ-012 out_ready  in  1  consumer accepts the result when out_valid and out_ready are both high.
REQ-013 filt_x[3], filt_y[3]  out  10 each  filtered locus per channel (0=red, 1=green, 2=blue).
REQ-014 vel_x[3], vel_y[3]  out  11 signed each  change in the filtered locus since the previous frame.
REQ-015 track_ok  out  3  per-channel lock flag.
REQ-016 overrun  out  1  sticky; a frame_ready arrived while the block was not in IDLE.

Function
REQ-017 The state machine SHALL have the states IDLE, START, WAIT, CAPTURE, FILT0, FILT1, FILT2 and PRESENT.
REQ-018 IDLE -> START on frame_ready; START asserts hunt_start for exactly one cycle and moves to WAIT.
REQ-019 In WAIT, hunt_done SHALL move the machine to CAPTURE, which latches all six inputs in that cycle.
REQ-020 If the WAIT counter reaches TIMEOUT with no hunt_done, the machine SHALL go to FILT0 and treat all three channels as misses.
REQ-021 FILT0..FILT2 SHALL each process one channel per cycle, then go to PRESENT; latency from hunt_done to out_valid is 5 cycles.
REQ-022 Hit: the pair is nonzero and, if track_ok, both per-axis |meas - filt| <= JUMP_MAX. Any other case is a miss.
REQ-023 Hit with track_ok=0: filt = meas, vel = 0, track_ok = 1, miss counter = 0.
REQ-024 Hit with track_ok=1: filt is updated by REQ-001 using arithmetic-right shift on an 11-bit signed difference; vel = new filt - old filt; miss counter = 0.
REQ-025 Miss: filt is held, vel = 0, miss counter increments and saturates at MISS_MAX; track_ok clears when it reaches MISS_MAX.
REQ-026 PRESENT asserts out_valid; outputs SHALL be stable while out_valid=1; on acceptance the machine returns to IDLE in the next cycle.
REQ-027 A frame_ready outside IDLE SHALL be dropped and SHALL set overrun; overrun clears only on reset.
REQ-028 A hunt_done outside WAIT SHALL be ignored.

Reset
REQ-029 On rst_n=0 the block SHALL go to IDLE immediately and clear every output, filter, velocity, miss counter and the timeout counter to 0, including mid-frame.
REQ-030 After reset release, the first frame_ready SHALL be honoured no earlier than the second rising clk edge.

Configuration
REQ-031 With LOCUS_VELOCITY_EN defined, vel_x and vel_y SHALL be computed per REQ-023..025; without it, they SHALL be constant 0 and the subtractors and old-value registers are removed.

Structure
REQ-032 A shared package locus_pkg SHALL hold the state enumeration, the channel-index constants, the coordinate width (10) and the velocity width (11).
REQ-033 One sub-module, locus_axis_filter, SHALL implement the single-axis hit test, filter update and velocity for one axis; it is instantiated twice (x, y) and time-shared across the channels.

Verification
REQ-034 Reset, then frame_ready and hunt_done with red=(80,80): out_valid exactly 5 cycles after hunt_done; filt_red = (80,80), vel = 0, track_ok[0] = 1.
REQ-035 Next frame with red=(96,80), ALPHA_SHIFT=2: filt_red_x = 84, vel_x = +4; filt_red_y = 80, vel_y = 0.
REQ-036 Next frame with red=(200,80) (jump 116 > 64): miss; filt held at 84; after 4 such frames track_ok[0] = 0, and the next frame with (200,80) loads 200 directly.
REQ-037 No hunt_done after hunt_start: after TIMEOUT cycles out_valid = 1, all misses, filt values unchanged.
REQ-038 out_ready held low for 10 cycles with frame_ready pulsed in between: outputs stable, overrun = 1, no second hunt_start.
REQ-039 rst_n pulsed low in WAIT: hunt_start, out_valid and track_ok go to 0 asynchronously; a later hunt_done is ignored until a new frame_ready.
